fetch_pc_unit: RTL and testbench
================================

FETCH_PC_UNIT -- requirements
Module: fetch_pc_unit

Interface
REQ-001 Parameter WORD_W, 32, address/data width.
REQ-002 Parameter QDEPTH, 4, prediction-queue entries (power of two, >=2).
REQ-003 Parameter RESET_PC, 32'h0000_0000, first fetch address.
REQ-004 CLK  in  1  clock; rising-edge.
REQ-005 nRST  in  1  reset, asynchronous, active-low.
REQ-006 pc  out  WORD_W  current fetch address; drives imem and branch predictor lookup.
REQ-007 imem_ren  out  1  fetch request.
REQ-008 ihit  in  1  imem accepted/returned the fetch at pc this cycle.
REQ-009 stall  in  1  decode cannot accept an instruction this cycle.
REQ-010 predicted_outcome  in  1  predictor taken prediction for pc.
REQ-011 predicted_target  in  WORD_W  predictor next-pc for pc (pc+4 when not taken).
REQ-012 rsv_valid  in  1  oldest in-flight instruction resolves this cycle.
REQ-013 rsv_is_branch  in  1  resolving instruction is a branch.
REQ-014 rsv_taken  in  1  actual branch outcome.
REQ-015 rsv_target  in  WORD_W  actual branch target.
REQ-016 flush  out  1  one-cycle pulse: discard all younger instructions.
REQ-017 update_btb, update_pc, branch_outcome, branch_target  out  1/WORD_W/1/WORD_W  predictor training port.
REQ-018 q_count  out  $clog2(QDEPTH)+1  queue occupancy.
REQ-019 mispredict_cnt  out  16  saturating mispredict counter.
REQ-020 underflow_err  out  1  sticky: resolve seen with empty queue.

Function
REQ-021 Queue entry = {pc, predicted_outcome, predicted_target}; in-order FIFO, head = oldest.
REQ-022 imem_ren = !full (q_count==QDEPTH).
REQ-023 Fetch fires when imem_ren && ihit && !stall: pc <= predicted_target, entry pushed; else pc holds.
REQ-024 Resolve fires when rsv_valid && !empty: head popped; rsv_valid on empty queue -> no pop, no update, underflow_err <= 1.
REQ-025 Actual next-pc = (rsv_is_branch && rsv_taken) ? rsv_target : head.pc+4 (modulo 2^WORD_W).
REQ-026 Mispredict = resolve fires && actual next-pc != head.predicted_target (covers non-branch aliasing predicted taken).
REQ-027 Mispredict: next cycle pc = actual next-pc, queue emptied (q_count=0), flush=1 for exactly one cycle, mispredict_cnt +1 saturating at 16'hFFFF.
REQ-028 Fetch and mispredict same cycle: mispredict wins, push discarded, pc from REQ-027.
REQ-029 Fetch and non-mispredicting resolve same cycle: push and pop both occur, q_count unchanged.
REQ-030 Training registered, one cycle after resolve: branch resolve -> update_btb=1, update_pc=head.pc, branch_outcome=rsv_taken, branch_target=rsv_target; non-branch with head.predicted_outcome=1 -> update_btb=1, branch_outcome=0 (invalidate); otherwise update_btb=0.
REQ-031 Read/write pointers wrap modulo QDEPTH; occupancy never exceeds QDEPTH nor goes below 0.
REQ-032 Fetch is blocked the cycle flush is high? No: fetch continues from redirected pc in the flush cycle.

Reset
REQ-033 nRST low, asynchronously: pc=RESET_PC, queue empty, q_count=0, flush=0, update_btb=0, update_pc=0, branch_outcome=0, branch_target=0, mispredict_cnt=0, underflow_err=0.
REQ-034 Reset mid-operation discards all queue contents and pending training; first fetch after release at RESET_PC.
REQ-035 underflow_err clears only by reset.

Verification
REQ-036 Sequential fetch: ihit=1, predicted_target=pc+4 for 4 cycles, no resolve -> pc 0x0,0x4,0x8,0xC,0x10, q_count=4, imem_ren=0, pc holds 0x10.
REQ-037 Correct taken branch: entry pc=0x8 predicted 0x40, resolve taken target 0x40 -> no flush, next cycle update_btb=1, update_pc=0x8, branch_target=0x40.
REQ-038 Mispredict: entry pc=0x10 predicted 0x14, resolve taken target 0x100 with fetch same cycle -> next cycle pc=0x100, q_count=0, flush=1 one cycle, mispredict_cnt=1.
REQ-039 Aliased non-branch: entry pc=0x20 predicted_outcome=1 target 0x80, resolve rsv_is_branch=0 -> pc=0x24, flush=1, update_btb=1, branch_outcome=0.
REQ-040 Full queue with simultaneous resolve (no mispredict) and stall=0 -> pop only (imem_ren=0), q_count=3; next cycle fetch resumes.
REQ-041 rsv_valid on empty queue -> underflow_err=1, stays 1 after further traffic; nRST pulse mid-run -> pc=0x0, q_count=0, underflow_err=0.

Source files
------------

// File: rtl/fetch_pc_unit.sv
// Fetch PC generation with an in-order prediction queue: tracks in-flight predictions,
// redirects on mispredict at resolve time and emits registered predictor training.
module fetch_pc_unit #(
    parameter int unsigned        WORD_W   = 32,
    parameter int unsigned        QDEPTH   = 4,
    parameter logic [WORD_W-1:0]  RESET_PC = '0
) (
    input  logic                      CLK,
    input  logic                      nRST,
    output logic [WORD_W-1:0]         pc,
    output logic                      imem_ren,
    input  logic                      ihit,
    input  logic                      stall,
    input  logic                      predicted_outcome,
    input  logic [WORD_W-1:0]         predicted_target,
    input  logic                      rsv_valid,
    input  logic                      rsv_is_branch,
    input  logic                      rsv_taken,
    input  logic [WORD_W-1:0]         rsv_target,
    output logic                      flush,
    output logic                      update_btb,
    output logic [WORD_W-1:0]         update_pc,
    output logic                      branch_outcome,
    output logic [WORD_W-1:0]         branch_target,
    output logic [$clog2(QDEPTH):0]   q_count,
    output logic [15:0]               mispredict_cnt,
    output logic                      underflow_err
);

    localparam int unsigned PTR_W = $clog2(QDEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    typedef struct packed {
        logic [WORD_W-1:0] pc;
        logic              pred_taken;
        logic [WORD_W-1:0] pred_target;
    } entry_t;

    entry_t             queue [QDEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               full_c;
    logic               empty_c;
    logic               fetch_fire_c;
    logic               resolve_fire_c;
    logic               mispredict_c;
    logic               push_c;
    entry_t             head_c;
    logic [WORD_W-1:0]  head_seq_c;
    logic [WORD_W-1:0]  actual_npc_c;

    // Handshake and resolve evaluation against the oldest entry
    always_comb begin
        full_c         = (count == CNT_W'(QDEPTH));
        empty_c        = (count == '0);
        head_c         = queue[rd_ptr];
        head_seq_c     = head_c.pc + WORD_W'(4);
        fetch_fire_c   = !full_c && ihit && !stall;
        resolve_fire_c = rsv_valid && !empty_c;
        actual_npc_c   = (rsv_is_branch && rsv_taken) ? rsv_target : head_seq_c;
        mispredict_c   = resolve_fire_c && (actual_npc_c != head_c.pred_target);
        push_c         = fetch_fire_c && !mispredict_c;
    end

    assign imem_ren = !full_c;
    assign q_count  = count;

    // Queue payload carries no reset; occupancy alone defines validity
    always_ff @(posedge CLK) begin
        if (push_c) begin
            queue[wr_ptr] <= '{pc: pc, pred_taken: predicted_outcome,
                               pred_target: predicted_target};
        end
    end

    // PC, pointers and occupancy; a mispredict squashes everything including a same-cycle push
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            pc     <= RESET_PC;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (mispredict_c) begin
            pc     <= actual_npc_c;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (fetch_fire_c) begin
                pc     <= predicted_target;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (resolve_fire_c) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count + CNT_W'(fetch_fire_c) - CNT_W'(resolve_fire_c);
        end
    end

    // Flush pulse, statistics and sticky underflow
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            flush          <= 1'b0;
            mispredict_cnt <= '0;
            underflow_err  <= 1'b0;
        end else begin
            flush <= mispredict_c;
            if (mispredict_c && (mispredict_cnt != 16'hFFFF)) begin
                mispredict_cnt <= mispredict_cnt + 16'd1;
            end
            if (rsv_valid && empty_c) begin
                underflow_err <= 1'b1;
            end
        end
    end

    // Predictor training: branches train, aliased non-branches invalidate
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            update_btb     <= 1'b0;
            update_pc      <= '0;
            branch_outcome <= 1'b0;
            branch_target  <= '0;
        end else begin
            update_btb <= resolve_fire_c && (rsv_is_branch || head_c.pred_taken);
            if (resolve_fire_c) begin
                update_pc      <= head_c.pc;
                branch_outcome <= rsv_is_branch && rsv_taken;
                branch_target  <= rsv_is_branch ? rsv_target : head_seq_c;
            end
        end
    end

endmodule

// File: tb/tb_fetch_pc_unit.sv
// Table-driven scoreboard bench for fetch_pc_unit: each vector drives one cycle and
// queues its hand-derived post-edge expectations, popped and compared after the edge.
module tb_fetch_pc_unit;

    logic        CLK = 1'b0;
    logic        nRST;
    logic [31:0] pc;
    logic        imem_ren;
    logic        ihit, stall, predicted_outcome;
    logic [31:0] predicted_target;
    logic        rsv_valid, rsv_is_branch, rsv_taken;
    logic [31:0] rsv_target;
    logic        flush, update_btb, branch_outcome;
    logic [31:0] update_pc, branch_target;
    logic [2:0]  q_count;
    logic [15:0] mispredict_cnt;
    logic        underflow_err;

    fetch_pc_unit #(.WORD_W(32), .QDEPTH(4), .RESET_PC(32'h0)) dut (
        .CLK(CLK), .nRST(nRST), .pc(pc), .imem_ren(imem_ren), .ihit(ihit), .stall(stall),
        .predicted_outcome(predicted_outcome), .predicted_target(predicted_target),
        .rsv_valid(rsv_valid), .rsv_is_branch(rsv_is_branch), .rsv_taken(rsv_taken),
        .rsv_target(rsv_target), .flush(flush), .update_btb(update_btb),
        .update_pc(update_pc), .branch_outcome(branch_outcome), .branch_target(branch_target),
        .q_count(q_count), .mispredict_cnt(mispredict_cnt), .underflow_err(underflow_err)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        ihit, stall, pout;
        logic [31:0] ptgt;
        logic        rv, rbr, rtk;
        logic [31:0] rtgt;
        logic [31:0] e_pc;
        logic [2:0]  e_cnt;
        logic        e_ren, e_flush, e_upd;
        logic [31:0] e_upc;
        logic        e_bo;
        logic [31:0] e_btgt;
        logic        chk_tgt;
        logic [15:0] e_mcnt;
        logic        e_uerr;
    } vec_t;

    vec_t vecs[$];
    vec_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    function automatic vec_t mk(
        input logic ih, input logic st, input logic po, input logic [31:0] pt,
        input logic rv, input logic rb, input logic rk, input logic [31:0] rt,
        input logic [31:0] epc, input logic [2:0] ecnt, input logic eren, input logic efl,
        input logic eupd, input logic [31:0] eupc, input logic ebo, input logic [31:0] ebt,
        input logic ct, input logic [15:0] emc, input logic eue);
        vec_t v;
        v.ihit = ih; v.stall = st; v.pout = po; v.ptgt = pt;
        v.rv = rv; v.rbr = rb; v.rtk = rk; v.rtgt = rt;
        v.e_pc = epc; v.e_cnt = ecnt; v.e_ren = eren; v.e_flush = efl; v.e_upd = eupd;
        v.e_upc = eupc; v.e_bo = ebo; v.e_btgt = ebt; v.chk_tgt = ct;
        v.e_mcnt = emc; v.e_uerr = eue;
        return v;
    endfunction

    task automatic chk(input string nm, input int idx, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
    endtask

    task automatic idle_inputs();
        ihit = 1'b0; stall = 1'b0; predicted_outcome = 1'b0; predicted_target = '0;
        rsv_valid = 1'b0; rsv_is_branch = 1'b0; rsv_taken = 1'b0; rsv_target = '0;
    endtask

    task automatic apply(input vec_t v, input int idx);
        vec_t e;
        @(negedge CLK);
        ihit = v.ihit; stall = v.stall; predicted_outcome = v.pout; predicted_target = v.ptgt;
        rsv_valid = v.rv; rsv_is_branch = v.rbr; rsv_taken = v.rtk; rsv_target = v.rtgt;
        sb.push_back(v);
        @(posedge CLK);
        #1;
        e = sb.pop_front();
        chk("pc", idx, pc, e.e_pc);
        chk("q_count", idx, 32'(q_count), 32'(e.e_cnt));
        chk("imem_ren", idx, 32'(imem_ren), 32'(e.e_ren));
        chk("flush", idx, 32'(flush), 32'(e.e_flush));
        chk("update_btb", idx, 32'(update_btb), 32'(e.e_upd));
        chk("mispredict_cnt", idx, 32'(mispredict_cnt), 32'(e.e_mcnt));
        chk("underflow_err", idx, 32'(underflow_err), 32'(e.e_uerr));
        if (e.e_upd) begin
            chk("update_pc", idx, update_pc, e.e_upc);
            chk("branch_outcome", idx, 32'(branch_outcome), 32'(e.e_bo));
            if (e.chk_tgt) chk("branch_target", idx, branch_target, e.e_btgt);
        end
    endtask

    initial begin
        //            ih st po ptgt       rv rb rk rtgt     | pc        cnt ren fl upd upc      bo btgt     ct mcnt uerr
        vecs.push_back(mk(1,0,0,32'h04,    0,0,0,32'h00,  32'h04,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,0,0,32'h08,    0,0,0,32'h00,  32'h08,   2, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,0,0,32'h0C,    0,0,0,32'h00,  32'h0C,   3, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,0,0,32'h10,    0,0,0,32'h00,  32'h10,   4, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,0,0,32'h14,    0,0,0,32'h00,  32'h10,   4, 0, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,0,0,32'h14,    1,0,0,32'h00,  32'h10,   3, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,0,0,32'h14,    1,0,0,32'h00,  32'h14,   3, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,1,0,32'h18,    1,1,0,32'h99,  32'h14,   2, 1, 0, 1, 32'h08,  0, 32'h99,  1, 0, 0));
        vecs.push_back(mk(0,0,0,32'h18,    1,0,0,32'h00,  32'h14,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 0, 0));
        vecs.push_back(mk(1,0,0,32'h18,    1,1,1,32'h100, 32'h100,  0, 1, 1, 1, 32'h10,  1, 32'h100, 1, 1, 0));
        vecs.push_back(mk(1,0,0,32'h104,   0,0,0,32'h00,  32'h104,  1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 1, 0));
        vecs.push_back(mk(0,0,0,32'h00,    1,1,1,32'h08,  32'h08,   0, 1, 1, 1, 32'h100, 1, 32'h08,  1, 2, 0));
        vecs.push_back(mk(1,0,1,32'h40,    0,0,0,32'h00,  32'h40,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 2, 0));
        vecs.push_back(mk(0,0,0,32'h00,    1,1,1,32'h40,  32'h40,   0, 1, 0, 1, 32'h08,  1, 32'h40,  1, 2, 0));
        vecs.push_back(mk(1,0,0,32'h44,    0,0,0,32'h00,  32'h44,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 2, 0));
        vecs.push_back(mk(0,0,0,32'h00,    1,1,1,32'h20,  32'h20,   0, 1, 1, 1, 32'h40,  1, 32'h20,  1, 3, 0));
        vecs.push_back(mk(1,0,1,32'h80,    0,0,0,32'h00,  32'h80,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 3, 0));
        vecs.push_back(mk(0,0,0,32'h00,    1,0,1,32'h55,  32'h24,   0, 1, 1, 1, 32'h20,  0, 32'h0,   0, 4, 0));
        vecs.push_back(mk(0,0,0,32'h00,    1,0,0,32'h00,  32'h24,   0, 1, 0, 0, 32'h0,   0, 32'h0,   0, 4, 1));
        vecs.push_back(mk(1,0,0,32'h28,    0,0,0,32'h00,  32'h28,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 4, 1));
        vecs.push_back(mk(1,0,0,32'h2C,    1,0,0,32'h00,  32'h2C,   1, 1, 0, 0, 32'h0,   0, 32'h0,   0, 4, 1));
        vecs.push_back(mk(1,0,0,32'h30,    0,0,0,32'h00,  32'h30,   2, 1, 0, 0, 32'h0,   0, 32'h0,   0, 4, 1));

        idle_inputs();
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        chk("rst_pc", 0, pc, 32'h0);
        chk("rst_q_count", 0, 32'(q_count), 32'd0);
        chk("rst_imem_ren", 0, 32'(imem_ren), 32'd1);
        chk("rst_flush", 0, 32'(flush), 32'd0);
        chk("rst_update_btb", 0, 32'(update_btb), 32'd0);
        chk("rst_mispredict_cnt", 0, 32'(mispredict_cnt), 32'd0);
        chk("rst_underflow_err", 0, 32'(underflow_err), 32'd0);
        @(negedge CLK);
        nRST = 1'b1;

        foreach (vecs[i]) apply(vecs[i], i);

        // Asynchronous reset mid-run with two entries in flight and a pending fetch
        @(negedge CLK);
        ihit = 1'b1; predicted_target = 32'h34; rsv_valid = 1'b1;
        #2;
        nRST = 1'b0;
        #1;
        chk("mid_rst_pc", 100, pc, 32'h0);
        chk("mid_rst_q_count", 100, 32'(q_count), 32'd0);
        chk("mid_rst_underflow_err", 100, 32'(underflow_err), 32'd0);
        chk("mid_rst_mispredict_cnt", 100, 32'(mispredict_cnt), 32'd0);
        chk("mid_rst_update_btb", 100, 32'(update_btb), 32'd0);
        @(posedge CLK);
        #1;
        chk("held_rst_pc", 101, pc, 32'h0);
        @(negedge CLK);
        idle_inputs();
        nRST = 1'b1;

        // First fetch after release starts at RESET_PC; old entries must be gone
        apply(mk(1,0,0,32'h04, 0,0,0,32'h0, 32'h04, 1, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0), 102);
        apply(mk(0,0,0,32'h00, 1,0,0,32'h0, 32'h04, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 0), 103);
        apply(mk(0,0,0,32'h00, 1,0,0,32'h0, 32'h04, 0, 1, 0, 0, 32'h0, 0, 32'h0, 0, 0, 1), 104);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
